x_uart_rx: RTL and testbench
============================

Name: x_uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's 8N1 transmitter, using the same clock/baud parameterisation.
- Synchronises the asynchronous serial input, detects the start bit, samples each bit at mid-bit, and emits each received byte as a one-cycle valid pulse.
- Sits between the board RX pin and the on-chip command/data consumer.
- No backpressure: the consumer must take the byte in the cycle o_valid is high.

Parameters:
- p_clk_hz, 12000000, system clock frequency in Hz.
- p_baud, 115200, line baud rate.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  last received byte; LSB is the first data bit received.
- o_valid  output  1  one-cycle pulse; o_data is new and valid this cycle.
- o_frame_err  output  1  one-cycle pulse on a bad stop bit (only present with X_UART_RX_FRAME_ERR_EN).

Behaviour:
- Constants:
  - p_timer_top = p_clk_hz/p_baud (integer division).
  - p_timer_half = p_timer_top/2.
  - Timer width = $clog2(p_timer_top+1).
- Input path:
  - i_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All FSM decisions use the synchronised value rx_s only.
- Timer:
  - Clears to 0 in IDLE.
  - Otherwise increments each cycle.
  - On reaching its compare value it wraps to 0 and generates a one-cycle tick.
  - Compare value is p_timer_half in START and p_timer_top in all other states.
- FSM states: IDLE, START, D0..D7, STOP, WAIT_IDLE.
- Transitions:
  - IDLE: rx_s==0 -> START, timer=0.
  - START, on tick (mid start bit):
    - rx_s==0 -> D0.
    - rx_s==1 -> IDLE (glitch rejected; nothing output).
  - Dn, on tick: shift register captures rx_s into bit n, then go to Dn+1; D7 goes to STOP.
  - STOP, on tick:
    - rx_s==1: o_data <= shift register, o_valid pulses for 1 cycle, -> IDLE.
    - rx_s==0: framing error; byte discarded, o_data unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then -> IDLE. This covers a break condition; no new start is detected while the line is low.
- Latency: o_valid rises about 9.5 bit times + 2 sync cycles after the start-bit falling edge, i.e. 2 + p_timer_half + 1 + 9*(p_timer_top+1) cycles (exact; bench checks ±1).
- Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge is caught with no gap.
- Reset values:
  - o_data=8'h00, o_valid=0, o_frame_err=0.
  - State=IDLE, timer=0, shift register=0.
- Reset mid-frame: everything returns to reset values immediately and the partial byte is lost. If the line is low when reset deasserts, the block treats it as a start edge.

Optional Feature:
- Macro: X_UART_RX_FRAME_ERR_EN.
- Defined:
  - Port o_frame_err exists.
  - It pulses high for exactly one cycle on the STOP->WAIT_IDLE transition.
  - It is never asserted in the same cycle as o_valid.
- Undefined:
  - Port is absent.
  - The framing-error path still discards the byte and goes through WAIT_IDLE, silently.

Decomposition:
- Package x_uart_pkg holds:
  - sm_uart_rx_t state enum.
  - A function computing timer top from (clk_hz, baud), shared with the TX block.
- Sub-module x_uart_sync: 2-flop synchroniser with parameterised reset value (1 here).
- FSM, timer and shift register stay in x_uart_rx.

Test Plan (p_clk_hz=12000000, p_baud=115200 -> top=104, half=52):
1. Single frame 8'hA5 at nominal baud -> exactly one o_valid pulse, o_data==8'hA5; latency within ±1 cycle of the formula.
2. Back-to-back frames 8'h00, 8'hFF, 8'h55 with no idle gap -> three o_valid pulses in order, no frame_err.
3. Low glitch of 20 cycles on i_rx while idle -> no o_valid; FSM back in IDLE by cycle ~55.
4. Frame 8'h3C with stop bit driven low, line held low for 2 bit times, then high, then frame 8'h81:
   - no o_valid for 8'h3C; o_frame_err pulses once (macro on);
   - 8'h81 received correctly.
5. Baud skew: frames sent at ±3% bit period (101 and 107 cycles/bit), data 8'hC3 -> correct o_data every time.
6. Assert i_rst during D4 of a frame, release, send 8'h5A -> outputs reset immediately; only 8'h5A reported afterwards.

Source files
------------

// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared types and helpers for the 8N1 UART blocks.
// Holds the RX state enum and the baud timer-top calculation used by RX and TX.
package x_uart_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_D0,
    S_D1,
    S_D2,
    S_D3,
    S_D4,
    S_D5,
    S_D6,
    S_D7,
    S_STOP,
    S_WAIT_IDLE
  } sm_uart_rx_t;

  // Clock cycles per bit, minus nothing: the timer counts 0..top inclusive.
  function automatic int unsigned f_timer_top(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/x_uart_sync.sv
// x_uart_sync: two-flop synchroniser for an asynchronous single-bit input.
// Ports: i_clk, i_rst (async active-high), i_d (async in), o_q (synchronised out).
module x_uart_sync #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= p_rst_val;
      r_q    <= p_rst_val;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/x_uart_rx.sv
// x_uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle valid pulse.
// Ports: i_clk, i_rst (async active-high), i_rx (serial in, idle high),
//   o_data (last byte, LSB first on the wire), o_valid (1-cycle pulse),
//   o_frame_err (1-cycle pulse on bad stop bit; only with X_UART_RX_FRAME_ERR_EN).
module x_uart_rx
  import x_uart_pkg::*;
#(
  parameter int unsigned p_clk_hz = 12000000,
  parameter int unsigned p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
`ifdef X_UART_RX_FRAME_ERR_EN
  ,
  output logic       o_frame_err
`endif
);

  localparam int unsigned p_timer_top  = f_timer_top(p_clk_hz, p_baud);
  localparam int unsigned p_timer_half = p_timer_top / 2;
  localparam int          p_tw         = $clog2(p_timer_top + 1);

  localparam logic [p_tw-1:0] p_cmp_top  = p_tw'(p_timer_top);
  localparam logic [p_tw-1:0] p_cmp_half = p_tw'(p_timer_half);

  logic            w_rx_s;
  logic [p_tw-1:0] w_cmp;
  logic            w_tick;

  sm_uart_rx_t     r_state;
  logic [p_tw-1:0] r_timer;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
`ifdef X_UART_RX_FRAME_ERR_EN
  logic            r_frame_err;
`endif

  x_uart_sync #(
    .p_rst_val(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (w_rx_s)
  );

  // Half-bit compare in START lands every later tick at mid-bit.
  assign w_cmp  = (r_state == S_START) ? p_cmp_half : p_cmp_top;
  assign w_tick = (r_state != S_IDLE) && (r_timer == w_cmp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
`ifdef X_UART_RX_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
`ifdef X_UART_RX_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif

      if (r_state == S_IDLE || w_tick) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + p_tw'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            // A line that is high again at mid start bit was a glitch.
            r_state <= w_rx_s ? S_IDLE : S_D0;
          end
        end
        S_D0, S_D1, S_D2, S_D3,
        S_D4, S_D5, S_D6, S_D7: begin
          if (w_tick) begin
            // LSB arrives first, so shifting right leaves it in bit 0.
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_state == S_D7) begin
              r_state <= S_STOP;
            end else begin
              r_state <= sm_uart_rx_t'(r_state + 4'd1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
`ifdef X_UART_RX_FRAME_ERR_EN
              r_frame_err <= 1'b1;
`endif
              r_state <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // Hold off start detection until a break releases the line.
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
`ifdef X_UART_RX_FRAME_ERR_EN
  assign o_frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_x_uart_rx.sv
// tb_x_uart_rx: self-checking bench for the 8N1 UART receiver.
// Drives framed bytes at nominal and skewed baud against a byte-queue model.
module tb_x_uart_rx;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned BAUD   = 115200;
  localparam int TOP  = int'(CLK_HZ / BAUD);
  localparam int HALF = TOP / 2;
  localparam int LAT  = 2 + HALF + 1 + 9 * (TOP + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
`ifdef X_UART_RX_FRAME_ERR_EN
  logic       ferr;
  int         ferr_n   = 0;
  int         exp_ferr = 0;
`endif

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t_start = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  x_uart_rx #(
    .p_clk_hz(CLK_HZ),
    .p_baud  (BAUD)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_rx   (rx),
    .o_data (data),
    .o_valid(valid)
`ifdef X_UART_RX_FRAME_ERR_EN
    ,
    .o_frame_err(ferr)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
`ifdef X_UART_RX_FRAME_ERR_EN
    if (ferr === 1'b1) begin
      ferr_n++;
      chk("ferr_with_valid", 32'(valid), 32'd0);
    end
`endif
  end

  task automatic bit_out(input logic v, input int per);
    rx = v;
    repeat (per) @(posedge clk);
    #1;
  endtask

  // Whole frame: start, 8 data bits LSB first, stop level as given.
  task automatic send(input logic [7:0] b, input int per, input logic stop);
    logic [7:0] v;
    v = b;
    t_start = cyc;
    bit_out(1'b0, per);
    for (int i = 0; i < 8; i++) bit_out(v[i], per);
    bit_out(stop, per);
    if (stop) exp_q.push_back(b);
`ifdef X_UART_RX_FRAME_ERR_EN
    else exp_ferr++;
`endif
  endtask

  task automatic clr();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int lat;
    int per;
    logic [7:0] b;
    logic stop;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    idle(10);

    // 1: single frame, latency
    clr();
    send(8'hA5, TOP, 1'b1);
    idle(20);
    check_rx("t1");
    lat = (got_t.size() > 0) ? got_t[0] - t_start : 0;
    chk("t1_latency_ok", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);

    // 2: back-to-back, no gap
    clr();
    send(8'h00, TOP, 1'b1);
    send(8'hFF, TOP, 1'b1);
    send(8'h55, TOP, 1'b1);
    idle(20);
    check_rx("t2");
`ifdef X_UART_RX_FRAME_ERR_EN
    chk("t2_ferr", 32'(ferr_n), 32'(exp_ferr));
`endif

    // 3: short low glitch is rejected, receiver ready again soon after
    clr();
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(40);
    chk("t3_glitch", 32'(got_q.size()), 32'd0);
    send(8'h96, TOP, 1'b1);
    idle(20);
    check_rx("t3");

    // 4: bad stop bit, break, then a good frame
    clr();
    send(8'h3C, TOP, 1'b0);
    rx = 1'b0;
    repeat (2 * TOP) @(posedge clk);
    #1;
    idle(TOP);
    chk("t4_no_valid", 32'(got_q.size()), 32'd0);
    chk("t4_data_kept", 32'(data), 32'h96);
`ifdef X_UART_RX_FRAME_ERR_EN
    chk("t4_ferr", 32'(ferr_n), 32'(exp_ferr));
`endif
    send(8'h81, TOP, 1'b1);
    idle(20);
    check_rx("t4");

    // 5: +/-3% baud skew
    clr();
    send(8'hC3, 101, 1'b1);
    send(8'hC3, 101, 1'b1);
    send(8'hC3, 107, 1'b1);
    send(8'hC3, 107, 1'b1);
    idle(20);
    check_rx("t5");

    // random bytes, skew and stop bits
    clr();
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom);
      per  = int'($urandom_range(101, 107));
      stop = ($urandom_range(0, 3) != 0);
      send(b, per, stop);
      if (!stop) begin
        rx = 1'b0;
        repeat (per) @(posedge clk);
        #1;
        idle(per);
      end
    end
    idle(20);
    check_rx("rnd");
`ifdef X_UART_RX_FRAME_ERR_EN
    chk("rnd_ferr", 32'(ferr_n), 32'(exp_ferr));
`endif

    // 6: reset during D4
    clr();
    send(8'hE7, TOP, 1'b1);
    idle(10);
    check_rx("t6_pre");
    clr();
    bit_out(1'b0, TOP);
    for (int i = 0; i < 4; i++) bit_out(1'b0, TOP);
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", 32'(data), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    send(8'h5A, TOP, 1'b1);
    idle(20);
    check_rx("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
